// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared widths, opcodes, FSM encodings and forwarding helpers for hazard_ctrl
package hazard_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int XADDR = 5;
  localparam int OPLEN = 7;

  localparam logic [OPLEN-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OPLEN-1:0] OP_AUIPC = 7'b0010111;
  localparam logic [OPLEN-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OPLEN-1:0] OP_JALR  = 7'b1100111;
  localparam logic [OPLEN-1:0] OP_B     = 7'b1100011;
  localparam logic [OPLEN-1:0] OP_L     = 7'b0000011;
  localparam logic [OPLEN-1:0] OP_S     = 7'b0100011;
  localparam logic [OPLEN-1:0] OP_I     = 7'b0010011;
  localparam logic [OPLEN-1:0] OP_R     = 7'b0110011;

  localparam logic [1:0] HC_RUN    = 2'd0;
  localparam logic [1:0] HC_STALL  = 2'd1;
  localparam logic [1:0] HC_FLUSH  = 2'd2;
  localparam logic [1:0] HC_FREEZE = 2'd3;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // A producer hits the decode instruction when it writes a non-zero rd that decode reads.
  function automatic logic rd_hits(input logic we, input logic [XADDR-1:0] rd,
                                   input logic [XADDR-1:0] rs1, input logic [XADDR-1:0] rs2,
                                   input logic use1, input logic use2);
    return we && (rd != '0) && ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
  endfunction

  // Youngest producer wins; x0 always reads the register file.
  function automatic logic [1:0] fwd_sel(input logic [XADDR-1:0] rs,
                                         input logic [XADDR-1:0] mem_rd, input logic mem_we,
                                         input logic [XADDR-1:0] wb_rd, input logic wb_we);
    if (rs == '0) return FWD_REG;
    if (mem_we && (mem_rd == rs)) return FWD_MEM;
    if (wb_we && (wb_rd == rs)) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hc_rs_use.sv
// rtl/hc_rs_use.sv - opcode decode of which source registers an instruction reads
module hc_rs_use
  import hazard_ctrl_pkg::*;
(
  input  logic [OPLEN-1:0] i_opcode,
  output logic             o_use_rs1,
  output logic             o_use_rs2
);

  // Unknown opcodes read nothing so they never stall the pipe.
  always_comb begin
    o_use_rs1 = 1'b0;
    o_use_rs2 = 1'b0;
    case (i_opcode)
      OP_I, OP_L, OP_JALR: o_use_rs1 = 1'b1;
      OP_R, OP_S, OP_B: begin
        o_use_rs1 = 1'b1;
        o_use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/freeze sequencer and forwarding select; HAZARD_CTRL_FORWARD_EN enables forwarding
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
)
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [OPLEN-1:0] i_id_opcode,
  input  logic [XADDR-1:0] i_id_rs1_addr,
  input  logic [XADDR-1:0] i_id_rs2_addr,
  input  logic [XADDR-1:0] i_ex_rs1_addr,
  input  logic [XADDR-1:0] i_ex_rs2_addr,
  input  logic [XADDR-1:0] i_ex_rd_addr,
  input  logic             i_ex_wr_en,
  input  logic             i_ex_is_load,
  input  logic [XADDR-1:0] i_mem_rd_addr,
  input  logic             i_mem_wr_en,
  input  logic [XADDR-1:0] i_wb_rd_addr,
  input  logic             i_wb_wr_en,
  input  logic             i_br_taken,
  input  logic             i_mem_busy,
  output logic             or_stall,
  output logic             or_flush,
  output logic             or_pc_hold,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic [1:0]       or_state
);

  // Counter holds the flush cycles still owed after the current one.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic       use_rs1;
  logic       use_rs2;
  logic       hazard;
  logic       hit_ex;
  logic [2:0] cnt;
  logic       pend;
  logic [1:0] state_nxt;
  logic [2:0] cnt_nxt;
  logic       pend_nxt;

  hc_rs_use u_rs_use (
    .i_opcode  (i_id_opcode),
    .o_use_rs1 (use_rs1),
    .o_use_rs2 (use_rs2)
  );

  assign hit_ex = rd_hits(i_ex_wr_en, i_ex_rd_addr, i_id_rs1_addr, i_id_rs2_addr, use_rs1, use_rs2);

`ifdef HAZARD_CTRL_FORWARD_EN
  // With forwarding only a load in EX cannot be bypassed in time.
  assign hazard  = i_ex_is_load && hit_ex;
  assign o_fwd_a = fwd_sel(i_ex_rs1_addr, i_mem_rd_addr, i_mem_wr_en, i_wb_rd_addr, i_wb_wr_en);
  assign o_fwd_b = fwd_sel(i_ex_rs2_addr, i_mem_rd_addr, i_mem_wr_en, i_wb_rd_addr, i_wb_wr_en);
`else
  logic unused_fwd_inputs;
  // Without forwarding decode waits until the producer has left writeback.
  assign hazard = hit_ex
                | rd_hits(i_mem_wr_en, i_mem_rd_addr, i_id_rs1_addr, i_id_rs2_addr, use_rs1, use_rs2)
                | rd_hits(i_wb_wr_en, i_wb_rd_addr, i_id_rs1_addr, i_id_rs2_addr, use_rs1, use_rs2);
  assign o_fwd_a = FWD_REG;
  assign o_fwd_b = FWD_REG;
  assign unused_fwd_inputs = ^{i_ex_is_load, i_ex_rs1_addr, i_ex_rs2_addr};
`endif

  // Next state: busy > branch > resumed/ongoing flush > hazard > run.
  always_comb begin
    state_nxt = HC_RUN;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    if (i_mem_busy) begin
      state_nxt = HC_FREEZE;
      if (or_state == HC_FLUSH) begin
        // The interrupted flush cycle counts as spent; resume owes what is left.
        pend_nxt = (cnt != 3'd0);
        cnt_nxt  = (cnt != 3'd0) ? cnt - 3'd1 : cnt;
      end else if (or_state != HC_FREEZE) begin
        pend_nxt = 1'b0;
      end
    end else if (i_br_taken) begin
      state_nxt = HC_FLUSH;
      cnt_nxt   = FLUSH_LOAD;
      pend_nxt  = 1'b0;
    end else if ((or_state == HC_FREEZE) && pend) begin
      state_nxt = HC_FLUSH;
      pend_nxt  = 1'b0;
    end else if ((or_state == HC_FLUSH) && (cnt != 3'd0)) begin
      state_nxt = HC_FLUSH;
      cnt_nxt   = cnt - 3'd1;
    end else if (hazard) begin
      state_nxt = HC_STALL;
    end
  end

  // Register state and decode-aligned control outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      or_state   <= HC_RUN;
      cnt        <= 3'd0;
      pend       <= 1'b0;
      or_stall   <= 1'b0;
      or_flush   <= 1'b0;
      or_pc_hold <= 1'b0;
    end else begin
      or_state   <= state_nxt;
      cnt        <= cnt_nxt;
      pend       <= pend_nxt;
      or_stall   <= (state_nxt == HC_STALL) || (state_nxt == HC_FREEZE);
      or_pc_hold <= (state_nxt == HC_STALL) || (state_nxt == HC_FREEZE);
      or_flush   <= (state_nxt == HC_FLUSH);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int FC = 2;

  logic       i_clk;
  logic       i_rst_n;
  logic [6:0] i_id_opcode;
  logic [4:0] i_id_rs1_addr, i_id_rs2_addr, i_ex_rs1_addr, i_ex_rs2_addr;
  logic [4:0] i_ex_rd_addr, i_mem_rd_addr, i_wb_rd_addr;
  logic       i_ex_wr_en, i_ex_is_load, i_mem_wr_en, i_wb_wr_en, i_br_taken, i_mem_busy;
  logic       or_stall, or_flush, or_pc_hold;
  logic [1:0] o_fwd_a, o_fwd_b, or_state;

  hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_opcode(i_id_opcode),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_ex_rs1_addr(i_ex_rs1_addr), .i_ex_rs2_addr(i_ex_rs2_addr),
    .i_ex_rd_addr(i_ex_rd_addr), .i_ex_wr_en(i_ex_wr_en), .i_ex_is_load(i_ex_is_load),
    .i_mem_rd_addr(i_mem_rd_addr), .i_mem_wr_en(i_mem_wr_en),
    .i_wb_rd_addr(i_wb_rd_addr), .i_wb_wr_en(i_wb_wr_en),
    .i_br_taken(i_br_taken), .i_mem_busy(i_mem_busy),
    .or_stall(or_stall), .or_flush(or_flush), .or_pc_hold(or_pc_hold),
    .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .or_state(or_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: number of flush cycles still owed, and expected registered state.
  int   owed  = 0;
  int   exp_st = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Set of architectural registers the decode instruction reads, x0 excluded.
  function automatic logic [31:0] read_set(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] m;
    m = 32'd0;
    if (op == OP_I || op == OP_L || op == OP_JALR) m[r1] = 1'b1;
    if (op == OP_R || op == OP_S || op == OP_B) begin
      m[r1] = 1'b1;
      m[r2] = 1'b1;
    end
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic int model_fwd(input logic [4:0] rs);
`ifdef HAZARD_CTRL_FORWARD_EN
    if (rs == 5'd0) return 0;
    if (i_mem_wr_en && i_mem_rd_addr == rs) return 1;
    if (i_wb_wr_en && i_wb_rd_addr == rs) return 2;
    return 0;
`else
    if (rs == 5'd31) return 0;
    return 0;
`endif
  endfunction

  task automatic model_step();
    logic [31:0] rs_set;
    bit          haz;
    rs_set = read_set(i_id_opcode, i_id_rs1_addr, i_id_rs2_addr);
`ifdef HAZARD_CTRL_FORWARD_EN
    haz = i_ex_is_load && i_ex_wr_en && rs_set[i_ex_rd_addr];
`else
    haz = (i_ex_wr_en && rs_set[i_ex_rd_addr]) || (i_mem_wr_en && rs_set[i_mem_rd_addr])
       || (i_wb_wr_en && rs_set[i_wb_rd_addr]);
`endif
    if (i_mem_busy) begin
      exp_st = 3;
    end else begin
      if (i_br_taken) owed = FC;
      if (owed > 0) begin
        exp_st = 2;
        owed--;
      end else begin
        exp_st = haz ? 1 : 0;
      end
    end
  endtask

  // Called at a negedge with inputs applied; ends at the next negedge after checking.
  task automatic run_cycle();
    #1;
    chk("fwd_a", 32'(o_fwd_a), 32'(model_fwd(i_ex_rs1_addr)));
    chk("fwd_b", 32'(o_fwd_b), 32'(model_fwd(i_ex_rs2_addr)));
    model_step();
    @(negedge i_clk);
    chk("state", 32'(or_state), 32'(exp_st));
    chk("stall", 32'(or_stall), 32'(exp_st == 1 || exp_st == 3));
    chk("pc_hold", 32'(or_pc_hold), 32'(exp_st == 1 || exp_st == 3));
    chk("flush", 32'(or_flush), 32'(exp_st == 2));
  endtask

  task automatic idle();
    i_id_opcode = 7'd0;
    i_id_rs1_addr = 5'd0; i_id_rs2_addr = 5'd0;
    i_ex_rs1_addr = 5'd0; i_ex_rs2_addr = 5'd0;
    i_ex_rd_addr = 5'd0; i_ex_wr_en = 1'b0; i_ex_is_load = 1'b0;
    i_mem_rd_addr = 5'd0; i_mem_wr_en = 1'b0;
    i_wb_rd_addr = 5'd0; i_wb_wr_en = 1'b0;
    i_br_taken = 1'b0; i_mem_busy = 1'b0;
  endtask

  logic [6:0] ops [10];

  initial begin
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_B, OP_L, OP_S, OP_I, OP_R, 7'h7f};
    idle();
    i_rst_n = 1'b0;
    #12;
    chk("rst_state", 32'(or_state), 32'd0);
    chk("rst_stall", 32'(or_stall), 32'd0);
    chk("rst_flush", 32'(or_flush), 32'd0);
    chk("rst_pc_hold", 32'(or_pc_hold), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

`ifdef HAZARD_CTRL_FORWARD_EN
    // Load-use: one stall, then forwarding from MEM.
    i_ex_rd_addr = 5'd5; i_ex_wr_en = 1'b1; i_ex_is_load = 1'b1;
    i_id_opcode = OP_R; i_id_rs1_addr = 5'd5; i_id_rs2_addr = 5'd1;
    run_cycle();
    chk("t1_stall_on", 32'(or_stall), 32'd1);
    i_ex_wr_en = 1'b0; i_ex_is_load = 1'b0; i_mem_rd_addr = 5'd5; i_mem_wr_en = 1'b1;
    run_cycle();
    chk("t1_stall_off", 32'(or_stall), 32'd0);
    idle();
    i_ex_rs1_addr = 5'd5; i_mem_rd_addr = 5'd5; i_mem_wr_en = 1'b1;
    run_cycle();
    chk("t1_fwd_a", 32'(o_fwd_a), 32'd1);
`else
    // RAW without forwarding: stall while x5 is in EX, MEM and WB.
    i_id_opcode = OP_R; i_id_rs1_addr = 5'd5; i_id_rs2_addr = 5'd0;
    i_ex_rd_addr = 5'd5; i_ex_wr_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_ex_wr_en = (k == 0); i_mem_wr_en = (k == 1); i_wb_wr_en = (k == 2);
      i_mem_rd_addr = 5'd5; i_wb_rd_addr = 5'd5;
      run_cycle();
      chk("t2_stall", 32'(or_stall), 32'(k < 3));
    end
`endif

    // Branch pulse, then branch extended by a second one.
    idle(); i_br_taken = 1'b1; run_cycle(); chk("t3a_st0", 32'(or_state), 32'd2);
    i_br_taken = 1'b0; run_cycle(); chk("t3a_st1", 32'(or_state), 32'd2);
    run_cycle(); chk("t3a_st2", 32'(or_state), 32'd0);
    i_br_taken = 1'b1; run_cycle();
    run_cycle();
    i_br_taken = 1'b0; run_cycle(); chk("t3b_st2", 32'(or_state), 32'd2);
    run_cycle(); chk("t3b_st3", 32'(or_state), 32'd0);

    // Branch beats simultaneous load-use.
    i_br_taken = 1'b1; i_ex_rd_addr = 5'd5; i_ex_wr_en = 1'b1; i_ex_is_load = 1'b1;
    i_id_opcode = OP_R; i_id_rs1_addr = 5'd5;
    run_cycle();
    chk("t4_state", 32'(or_state), 32'd2);
    chk("t4_stall", 32'(or_stall), 32'd0);
    idle(); run_cycle(); run_cycle();

    // Freeze during flush resumes the remaining flush cycle.
    i_br_taken = 1'b1; run_cycle(); i_br_taken = 1'b0;
    i_mem_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_cycle();
      chk("t5_freeze", 32'(or_state), 32'd3);
    end
    i_mem_busy = 1'b0;
    run_cycle(); chk("t5_resume", 32'(or_state), 32'd2);
    run_cycle(); chk("t5_run", 32'(or_state), 32'd0);

    // x0 never hazards nor forwards.
    idle();
    i_id_opcode = OP_I; i_ex_rd_addr = 5'd0; i_ex_wr_en = 1'b1; i_ex_is_load = 1'b1;
    i_mem_wr_en = 1'b1; i_wb_wr_en = 1'b1;
    run_cycle();
    chk("t6_stall", 32'(or_stall), 32'd0);
    chk("t6_fwd_a", 32'(o_fwd_a), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      i_id_opcode   = ops[$urandom_range(0, 9)];
      i_id_rs1_addr = 5'($urandom_range(0, 3));
      i_id_rs2_addr = 5'($urandom_range(0, 3));
      i_ex_rs1_addr = 5'($urandom_range(0, 3));
      i_ex_rs2_addr = 5'($urandom_range(0, 3));
      i_ex_rd_addr  = 5'($urandom_range(0, 3));
      i_mem_rd_addr = 5'($urandom_range(0, 3));
      i_wb_rd_addr  = 5'($urandom_range(0, 3));
      i_ex_wr_en    = 1'($urandom_range(0, 1));
      i_ex_is_load  = 1'($urandom_range(0, 1));
      i_mem_wr_en   = 1'($urandom_range(0, 1));
      i_wb_wr_en    = 1'($urandom_range(0, 1));
      i_br_taken    = ($urandom_range(0, 7) == 0);
      i_mem_busy    = ($urandom_range(0, 5) == 0);
      run_cycle();
    end

    // Asynchronous reset in the middle of a stall.
    idle();
    i_id_opcode = OP_R; i_id_rs1_addr = 5'd5; i_ex_rd_addr = 5'd5; i_ex_wr_en = 1'b1;
    i_ex_is_load = 1'b1;
    run_cycle();
    chk("t7_pre", 32'(or_state), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t7_state", 32'(or_state), 32'd0);
    chk("t7_stall", 32'(or_stall), 32'd0);
    chk("t7_pc_hold", 32'(or_pc_hold), 32'd0);
    chk("t7_flush", 32'(or_flush), 32'd0);
    owed = 0; exp_st = 0;
    idle();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
